regfile_access_arbiter: RTL and testbench

- Shares one 64x16 dual-read register file between two requesters (n = 0, 1) with round-robin arbitration.
- Sequences each access through the register file's timing rules:
  - A write cycle suppresses reads.
  - Read data is registered one cycle after the address is presented.
- Sits between the register file and its two clients (e.g. datapath sequencer and debug/load port).
- Returns read data and a completion pulse to the client that issued the access.

---
 rtl/regfile_access_arbiter.sv | 99 +++++++++
 tb/tb_regfile_access_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_access_arbiter.sv
// regfile_access_arbiter: round-robin sharing of a 64x16 dual-read register file
// between two clients, one access per IDLE -> ISSUE -> CAPTURE pass.
module regfile_access_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Req0,
    input  logic                  Write0,
    input  logic [ADDR_WIDTH-1:0] AddrA0,
    input  logic [ADDR_WIDTH-1:0] AddrB0,
    input  logic [DATA_WIDTH-1:0] WData0,
    input  logic                  Req1,
    input  logic                  Write1,
    input  logic [ADDR_WIDTH-1:0] AddrA1,
    input  logic [ADDR_WIDTH-1:0] AddrB1,
    input  logic [DATA_WIDTH-1:0] WData1,
    output logic                  Grant0,
    output logic                  Grant1,
    output logic                  Done0,
    output logic                  Done1,
    output logic [DATA_WIDTH-1:0] RDataA0,
    output logic [DATA_WIDTH-1:0] RDataB0,
    output logic [DATA_WIDTH-1:0] RDataA1,
    output logic [DATA_WIDTH-1:0] RDataB1,
    output logic [ADDR_WIDTH-1:0] RfAddressA,
    output logic [ADDR_WIDTH-1:0] RfAddressB,
    output logic [DATA_WIDTH-1:0] RfWriteData,
    output logic                  RfWriteEnable,
    input  logic [DATA_WIDTH-1:0] RfReadDataA,
    input  logic [DATA_WIDTH-1:0] RfReadDataB,
    output logic                  Busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;
    state_t state, state_nx;
    logic   any_req, sel, last, is_write;

    always_comb begin
        any_req  = Req0 | Req1;
        sel      = (Req0 & Req1) ? ~last : Req1;
        state_nx = (state == IDLE)  ? (any_req ? ISSUE : IDLE) :
                   (state == ISSUE) ? CAPTURE : IDLE;
    end

    always_ff @(posedge Clock or posedge Reset)
        if (Reset) state <= IDLE;
        else       state <= state_nx;

    // last doubles as the owner of the access in flight
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            last          <= 1'b1;
            is_write      <= 1'b0;
            Grant0        <= 1'b0;
            Grant1        <= 1'b0;
            Done0         <= 1'b0;
            Done1         <= 1'b0;
            Busy          <= 1'b0;
            RfAddressA    <= '0;
            RfAddressB    <= '0;
            RfWriteData   <= '0;
            RfWriteEnable <= 1'b0;
            RDataA0       <= '0;
            RDataB0       <= '0;
            RDataA1       <= '0;
            RDataB1       <= '0;
        end else begin
            Grant0 <= 1'b0;
            Grant1 <= 1'b0;
            Done0  <= 1'b0;
            Done1  <= 1'b0;
            Busy   <= state_nx != IDLE;
            if (state == IDLE && any_req) begin
                RfAddressA    <= sel ? AddrA1 : AddrA0;
                RfAddressB    <= sel ? AddrB1 : AddrB0;
                RfWriteData   <= sel ? WData1 : WData0;
                RfWriteEnable <= sel ? Write1 : Write0;
                is_write      <= sel ? Write1 : Write0;
                Grant0        <= ~sel;
                Grant1        <= sel;
                last          <= sel;
            end
            if (state == ISSUE) RfWriteEnable <= 1'b0;
            if (state == CAPTURE) begin
                Done0 <= ~last;
                Done1 <= last;
                if (!is_write && !last) begin
                    RDataA0 <= RfReadDataA;
                    RDataB0 <= RfReadDataB;
                end
                if (!is_write && last) begin
                    RDataA1 <= RfReadDataA;
                    RDataB1 <= RfReadDataB;
                end
            end
        end
    end
endmodule

// File: tb/tb_regfile_access_arbiter.sv
// tb_regfile_access_arbiter: scoreboard bench with a behavioural register file
// model attached to the Rf* port.
module tb_regfile_access_arbiter;
    logic        Clock = 0, Reset = 1;
    logic        Req0 = 0, Write0 = 0, Req1 = 0, Write1 = 0;
    logic [5:0]  AddrA0 = 0, AddrB0 = 0, AddrA1 = 0, AddrB1 = 0;
    logic [15:0] WData0 = 0, WData1 = 0;
    logic        Grant0, Grant1, Done0, Done1, RfWriteEnable, Busy;
    logic [15:0] RDataA0, RDataB0, RDataA1, RDataB1, RfWriteData;
    logic [15:0] RfReadDataA = 0, RfReadDataB = 0;
    logic [5:0]  RfAddressA, RfAddressB;

    typedef struct packed {
        logic        n;
        logic [15:0] a0, b0, a1, b1;
    } exp_t;
    exp_t        q[$];
    logic [15:0] mem[64];
    logic [15:0] shadow[64];
    logic [15:0] la[2], lb[2];
    int          vectors = 0, miscompares = 0;

    always #5 Clock = ~Clock;

    regfile_access_arbiter dut (
        .Clock(Clock), .Reset(Reset),
        .Req0(Req0), .Write0(Write0), .AddrA0(AddrA0), .AddrB0(AddrB0), .WData0(WData0),
        .Req1(Req1), .Write1(Write1), .AddrA1(AddrA1), .AddrB1(AddrB1), .WData1(WData1),
        .Grant0(Grant0), .Grant1(Grant1), .Done0(Done0), .Done1(Done1),
        .RDataA0(RDataA0), .RDataB0(RDataB0), .RDataA1(RDataA1), .RDataB1(RDataB1),
        .RfAddressA(RfAddressA), .RfAddressB(RfAddressB), .RfWriteData(RfWriteData),
        .RfWriteEnable(RfWriteEnable), .RfReadDataA(RfReadDataA), .RfReadDataB(RfReadDataB),
        .Busy(Busy)
    );

    // register file: a write cycle suppresses the registered read
    always @(posedge Clock)
        if (RfWriteEnable) mem[RfAddressA] <= RfWriteData;
        else begin
            RfReadDataA <= mem[RfAddressA];
            RfReadDataB <= mem[RfAddressB];
        end

    initial for (int i = 0; i < 64; i++) mem[i] = 16'hC000 | 16'(i);

    always @(negedge Clock) begin
        if (Grant0 && Grant1) begin
            vectors++;
            miscompares++;
            $display("FAIL grant_exclusive: both grants high at %0t", $time);
        end
        if (Done0 || Done1) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done: Done0=%b Done1=%b with nothing outstanding at %0t", Done0, Done1, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({Done0, Done1, RDataA0, RDataB0, RDataA1, RDataB1} !== {~e.n, e.n, e.a0, e.b0, e.a1, e.b1}) begin
                    miscompares++;
                    $display("FAIL done_data: got done=%b%b rd0=%h/%h rd1=%h/%h, want done=%b%b rd0=%h/%h rd1=%h/%h",
                             Done0, Done1, RDataA0, RDataB0, RDataA1, RDataB1, ~e.n, e.n, e.a0, e.b0, e.a1, e.b1);
                end
            end
        end
    end

    function automatic void expect_op(input logic n, input logic w, input logic [5:0] a, input logic [5:0] b, input logic [15:0] d);
        if (w) shadow[a] = d;
        else begin
            la[n] = shadow[a];
            lb[n] = shadow[b];
        end
        q.push_back({n, la[0], lb[0], la[1], lb[1]});
    endfunction

    task automatic drive(input logic n, input logic w, input logic [5:0] a, input logic [5:0] b, input logic [15:0] d);
        if (n) begin
            Req1 = 1; Write1 = w; AddrA1 = a; AddrB1 = b; WData1 = d;
        end else begin
            Req0 = 1; Write0 = w; AddrA0 = a; AddrB0 = b; WData0 = d;
        end
    endtask

    task automatic wait_grant(input logic n, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge Clock);
            if ((n ? Grant1 : Grant0) === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic drain(input string name);
        int left;
        left = 0;
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge Clock);
        left = q.size();
        vectors++;
        if (left !== 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d accesses still outstanding, want 0", name, left);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 64; i++) shadow[i] = 16'hC000 | 16'(i);
        la = '{16'h0, 16'h0};
        lb = '{16'h0, 16'h0};
        repeat (2) @(negedge Clock);
        vectors++;
        if ({Grant0, Grant1, Done0, Done1, Busy, RfWriteEnable, RfAddressA, RfAddressB, RfWriteData,
             RDataA0, RDataB0, RDataA1, RDataB1} !== '0) begin
            miscompares++;
            $display("FAIL reset_values: outputs not all zero (Busy=%b WE=%b AA=%h WD=%h)", Busy, RfWriteEnable, RfAddressA, RfWriteData);
        end
        Reset = 0;
    endtask

    task automatic test_write();
        drive(0, 1, 5, 0, 16'hBEEF);
        expect_op(0, 1, 5, 0, 16'hBEEF);
        @(negedge Clock);
        Req0 = 0;
        vectors++;
        if ({Grant0, Grant1, RfWriteEnable, Busy, RfAddressA, RfWriteData} !== {4'b1011, 6'd5, 16'hBEEF}) begin
            miscompares++;
            $display("FAIL write_grant: G0=%b G1=%b WE=%b Busy=%b AA=%0d WD=%h, want 1 0 1 1 5 beef",
                     Grant0, Grant1, RfWriteEnable, Busy, RfAddressA, RfWriteData);
        end
        @(negedge Clock);
        vectors++;
        if ({Grant0, RfWriteEnable, Busy, Done0} !== 4'b0010) begin
            miscompares++;
            $display("FAIL write_issue: G0=%b WE=%b Busy=%b D0=%b, want 0 0 1 0", Grant0, RfWriteEnable, Busy, Done0);
        end
        @(negedge Clock);
        vectors++;
        if (Done0 !== 1'b1) begin
            miscompares++;
            $display("FAIL write_done: Done0=%b, want 1", Done0);
        end
        @(negedge Clock);
        vectors++;
        if (Done0 !== 1'b0) begin
            miscompares++;
            $display("FAIL write_done_pulse: Done0=%b a cycle later, want 0", Done0);
        end
    endtask

    task automatic test_read();
        drive(1, 0, 5, 0, 16'h0);
        expect_op(1, 0, 5, 0, 16'h0);
        @(negedge Clock);
        Req1 = 0;
        vectors++;
        if ({Grant0, Grant1} !== 2'b01) begin
            miscompares++;
            $display("FAIL read_grant: G0=%b G1=%b, want 0 1", Grant0, Grant1);
        end
        repeat (2) @(negedge Clock);
        vectors++;
        if ({Done1, RDataA1, RDataB1, RDataA0} !== {1'b1, 16'hBEEF, 16'hC000, 16'h0}) begin
            miscompares++;
            $display("FAIL read_data: D1=%b A1=%h B1=%h A0=%h, want 1 beef c000 0000", Done1, RDataA1, RDataB1, RDataA0);
        end
    endtask

    task automatic test_round_robin();
        int gn[4], gt[4], ng;
        ng = 0;
        for (int i = 0; i < 4; i++) expect_op(1'(i % 2), 0, (i % 2) ? 6'd20 : 6'd10, (i % 2) ? 6'd21 : 6'd11, 16'h0);
        drive(0, 0, 10, 11, 16'h0);
        drive(1, 0, 20, 21, 16'h0);
        for (int i = 0; i < 12; i++) begin
            @(negedge Clock);
            if ((Grant0 || Grant1) && ng < 4) begin
                gn[ng] = Grant1 ? 1 : 0;
                gt[ng] = i;
                ng++;
            end
        end
        Req0 = 0;
        Req1 = 0;
        vectors++;
        if (ng !== 4) begin
            miscompares++;
            $display("FAIL rr_count: %0d grants in 12 cycles, want 4", ng);
        end
        for (int i = 0; i < ng; i++) begin
            vectors++;
            if (gn[i] !== i % 2 || gt[i] !== 3 * i) begin
                miscompares++;
                $display("FAIL rr_grant%0d: requester %0d at cycle %0d, want requester %0d at cycle %0d", i, gn[i], gt[i], i % 2, 3 * i);
            end
        end
        drain("rr");
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        drive(0, 1, 63, 0, 16'h1234);
        expect_op(0, 1, 63, 0, 16'h1234);
        wait_grant(0, c1);
        drive(0, 0, 63, 63, 16'h0);
        expect_op(0, 0, 63, 63, 16'h0);
        wait_grant(0, c2);
        Req0 = 0;
        vectors++;
        if (c1 !== 1 || c2 !== 3) begin
            miscompares++;
            $display("FAIL b2b_spacing: grant latencies %0d,%0d, want 1,3", c1, c2);
        end
        drain("b2b");
        vectors++;
        if ({RDataA0, RDataB0} !== {16'h1234, 16'h1234}) begin
            miscompares++;
            $display("FAIL b2b_raw: A0=%h B0=%h, want 1234 1234", RDataA0, RDataB0);
        end
    endtask

    task automatic test_reset_abort();
        int c;
        drive(0, 1, 7, 0, 16'hAAAA);
        @(negedge Clock);
        vectors++;
        if ({Grant0, RfWriteEnable} !== 2'b11) begin
            miscompares++;
            $display("FAIL abort_setup: G0=%b WE=%b, want 1 1", Grant0, RfWriteEnable);
        end
        Req0 = 0;
        Reset = 1;
        #1;
        vectors++;
        if ({Busy, RfWriteEnable} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_async: Busy=%b WE=%b right after reset, want 0 0", Busy, RfWriteEnable);
        end
        @(negedge Clock);
        Reset = 0;
        la = '{16'h0, 16'h0};
        lb = '{16'h0, 16'h0};
        repeat (4) @(negedge Clock);
        drive(0, 0, 7, 7, 16'h0);
        expect_op(0, 0, 7, 7, 16'h0);
        wait_grant(0, c);
        Req0 = 0;
        drain("abort");
        vectors++;
        if ({RDataA0, RDataB0} !== {16'hC007, 16'hC007}) begin
            miscompares++;
            $display("FAIL abort_lost_write: A0=%h B0=%h, want c007 c007", RDataA0, RDataB0);
        end
    endtask

    task automatic test_req1_stream();
        int g0, g1, d1;
        g0 = 0; g1 = 0; d1 = 0;
        for (int i = 0; i < 3; i++) expect_op(1, 0, 30, 31, 16'h0);
        drive(1, 0, 30, 31, 16'h0);
        for (int i = 0; i < 9; i++) begin
            @(negedge Clock);
            g0 += int'(Grant0);
            g1 += int'(Grant1);
            d1 += int'(Done1);
        end
        Req1 = 0;
        vectors++;
        if (g0 !== 0 || g1 !== 3 || d1 !== 3) begin
            miscompares++;
            $display("FAIL stream1: grant0=%0d grant1=%0d done1=%0d, want 0 3 3", g0, g1, d1);
        end
        drain("stream1");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_back_to_back();
        test_reset_abort();
        test_req1_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
